// File: rtl/vadd_engine.sv
// vadd_engine: compute-side sequencer for the vector-add datapath.
// Reads A[i] and B[i] through BRAM Port B, writes C[i] = A[i] + B[i],
// then pulses done. Port B controls are decoded from the state register.
module vadd_engine #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] c_base,
  input  logic [31:0]           len,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] comp_addr_b,
  output logic [DATA_WIDTH-1:0] comp_din_b,
  input  logic [DATA_WIDTH-1:0] comp_dout_b,
  output logic                  comp_en_b,
  output logic                  comp_we_b
);

  localparam int unsigned LEN_W = 32;
  localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_WAIT_A,
    S_RD_B,
    S_WAIT_B,
    S_WR,
    S_DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;

  logic [ADDR_WIDTH-1:0] a_base_q;
  logic [ADDR_WIDTH-1:0] b_base_q;
  logic [ADDR_WIDTH-1:0] c_base_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      idx_q;
  logic [CNT_W-1:0]      wait_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  overflow_q;

  logic [DATA_WIDTH-1:0] sum_c;
  logic                  ovf_c;
  logic                  last_elem_c;
  logic                  wait_last_c;
  logic [ADDR_WIDTH-1:0] idx_addr_c;

  logic                  en_c;
  logic                  we_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [DATA_WIDTH-1:0] din_c;

  // Element arithmetic: wrapping sum, signed overflow, loop and wait terminals
  assign sum_c       = a_q + b_q;
  assign ovf_c       = (a_q[DATA_WIDTH-1] == b_q[DATA_WIDTH-1]) &&
                       (sum_c[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
  assign last_elem_c = (idx_q == (len_q - LEN_W'(1)));
  assign wait_last_c = (wait_q == WAIT_LAST);
  assign idx_addr_c  = ADDR_WIDTH'(idx_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and raw Port B decode
  always_comb begin
    state_d = state_q;
    en_c    = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    din_c   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? S_DONE : S_RD_A;
        end
      end
      S_RD_A: begin
        en_c    = 1'b1;
        addr_c  = a_base_q + idx_addr_c;
        state_d = S_WAIT_A;
      end
      S_WAIT_A: begin
        if (wait_last_c) begin
          state_d = S_RD_B;
        end
      end
      S_RD_B: begin
        en_c    = 1'b1;
        addr_c  = b_base_q + idx_addr_c;
        state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (wait_last_c) begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        en_c    = 1'b1;
        we_c    = 1'b1;
        addr_c  = c_base_q + idx_addr_c;
        din_c   = sum_c;
        state_d = last_elem_c ? S_DONE : S_RD_A;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Port B drive; a reset cycle blocks any access, including a pending write
  assign comp_en_b   = en_c & ~rst;
  assign comp_we_b   = we_c & ~rst;
  assign comp_addr_b = comp_en_b ? addr_c : '0;
  assign comp_din_b  = comp_en_b ? din_c  : '0;

  // Status decoded from the state register
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign overflow = overflow_q;

  // Launch latching, index, read-wait counter, operand capture, overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_base_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      wait_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_base_q   <= a_base;
            b_base_q   <= b_base;
            c_base_q   <= c_base;
            len_q      <= len;
            idx_q      <= '0;
            wait_q     <= '0;
            overflow_q <= 1'b0;
          end
        end
        S_WAIT_A: begin
          if (wait_last_c) begin
            a_q    <= comp_dout_b;
            wait_q <= '0;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        S_WAIT_B: begin
          if (wait_last_c) begin
            b_q    <= comp_dout_b;
            wait_q <= '0;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        S_WR: begin
          if (ovf_c) begin
            overflow_q <= 1'b1;
          end
          idx_q <= idx_q + LEN_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
